// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register with the load-use hazard detector.
//   It captures the decoded control fields, operands and register addresses
//   at the end of ID and presents them to EX one cycle later. The register
//   can also hold its contents (freeze) or load a bubble (flush or load-use
//   hazard). A saturating counter records how many bubbles were inserted.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   id_valid, *_in    decoded ID-stage instruction
//   freeze            hold every register (memory stall)
//   flush             taken branch in EX; replace the ID instruction with a bubble
//   *_q, valid_q      registered EX-stage instruction
//   hazard_stall      combinational; hold PC and IF/ID this cycle
//   bubble_cnt        number of bubbles inserted by flush or hazard
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        alu_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic [1:0]        branch_type_in,
  input  logic              is_imm_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic              src2_used_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              freeze,
  input  logic              flush,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] val1_q,
  output logic [DATA_W-1:0] val2_q,
  output logic [DATA_W-1:0] st_val_q,
  output logic [3:0]        alu_cmd_q,
  output logic              mem_read_q,
  output logic              mem_write_q,
  output logic              wb_en_q,
  output logic              is_imm_q,
  output logic [1:0]        branch_type_q,
  output logic [REG_AW-1:0] dest_q,
  output logic              valid_q,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DATA_W-1:0] pc_d, val1_d, val2_d, st_val_d;
  logic [3:0]        alu_cmd_d;
  logic              mem_read_d, mem_write_d, wb_en_d, is_imm_d;
  logic [1:0]        branch_type_d;
  logic [REG_AW-1:0] dest_d;
  logic              valid_d;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic              ex_is_load;
  logic              src_match;

  // A load to r0 produces nothing to forward, so it can never cause a stall.
  // Bubbles carry valid_q=0, which guarantees the stall lasts one cycle.
  assign ex_is_load   = valid_q & mem_read_q & wb_en_q & (dest_q != '0);
  assign src_match    = (dest_q == src1_in) | (src2_used_in & (dest_q == src2_in));
  assign hazard_stall = rst_n & ex_is_load & id_valid & ~flush & src_match;
  assign bubble_cnt   = bubble_cnt_q;

  always_comb begin
    pc_d          = pc_q;
    val1_d        = val1_q;
    val2_d        = val2_q;
    st_val_d      = st_val_q;
    alu_cmd_d     = alu_cmd_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    wb_en_d       = wb_en_q;
    is_imm_d      = is_imm_q;
    branch_type_d = branch_type_q;
    dest_d        = dest_q;
    valid_d       = valid_q;
    bubble_cnt_d  = bubble_cnt_q;
    if (!freeze) begin
      if (flush || hazard_stall) begin
        pc_d          = '0;
        val1_d        = '0;
        val2_d        = '0;
        st_val_d      = '0;
        alu_cmd_d     = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        wb_en_d       = 1'b0;
        is_imm_d      = 1'b0;
        branch_type_d = '0;
        dest_d        = '0;
        valid_d       = 1'b0;
        if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
        pc_d          = pc_in;
        val1_d        = val1_in;
        val2_d        = val2_in;
        st_val_d      = st_val_in;
        alu_cmd_d     = alu_cmd_in;
        is_imm_d      = is_imm_in;
        dest_d        = dest_in;
        valid_d       = id_valid;
        // Side-effecting controls are gated so an empty slot does nothing in EX.
        mem_read_d    = mem_read_in  & id_valid;
        mem_write_d   = mem_write_in & id_valid;
        wb_en_d       = wb_en_in     & id_valid;
        branch_type_d = branch_type_in & {2{id_valid}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= '0;
      val1_q        <= '0;
      val2_q        <= '0;
      st_val_q      <= '0;
      alu_cmd_q     <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      is_imm_q      <= 1'b0;
      branch_type_q <= '0;
      dest_q        <= '0;
      valid_q       <= 1'b0;
      bubble_cnt_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
      st_val_q      <= st_val_d;
      alu_cmd_q     <= alu_cmd_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      wb_en_q       <= wb_en_d;
      is_imm_q      <= is_imm_d;
      branch_type_q <= branch_type_d;
      dest_q        <= dest_d;
      valid_q       <= valid_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

endmodule
